sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_pkg.sv | 14 +
 rtl/sdram_arbiter_tag_fifo.sv | 49 ++++
 rtl/sdram_arbiter.sv | 131 +++++++++++++
 tb/tb_sdram_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types and widths for the SDRAM read arbiter: FSM encoding,
// SDRAM address/data widths and requester age-counter width.
package sdram_pkg;
    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;
    localparam int AGE_W  = 4;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/sdram_arbiter_tag_fifo.sv
// Small FIFO of requester tags for reads the SDRAM has accepted but not yet
// returned; head is the requester that owns the next sdram_valid.
module tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_tag,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    // Explicit wrap keeps DEPTH=1 correct despite the 1-bit minimum pointer.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= push_tag;
endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates ROM read requesters onto one SDRAM port with an age-based
// fairness override, and passes ROM-download writes through once reads drain.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int AGE_LIMIT  = 8,
    parameter int PEND_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        valid,
    input  logic                      dl_active,
    input  logic                      dl_req,
    input  logic [ADDR_W-1:0]         dl_addr,
    input  logic [DATA_W-1:0]         dl_data,
    output logic                      sdram_req,
    output logic                      sdram_we,
    output logic [ADDR_W-1:0]         sdram_addr,
    output logic [DATA_W-1:0]         sdram_data,
    input  logic                      sdram_ack,
    input  logic                      sdram_valid,
    output logic                      overflow_err
);
    localparam int TW = $clog2(NUM_REQ);

    state_t                        state, state_n;
    logic [TW-1:0]                 grant, winner, head, old_sel, req_sel;
    logic                          old_hit;
    logic [NUM_REQ-1:0][AGE_W-1:0] age;
    logic                          full, empty, push, pop;

    tag_fifo #(.WIDTH(TW), .DEPTH(PEND_DEPTH)) u_tags (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_tag (grant),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    // Scan high to low so the lowest qualifying index is the one left standing.
    always_comb begin
        old_sel = '0;
        req_sel = '0;
        old_hit = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) req_sel = TW'(i);
            if (req[i] && age[i] >= AGE_W'(AGE_LIMIT)) begin
                old_sel = TW'(i);
                old_hit = 1'b1;
            end
        end
        winner = old_hit ? old_sel : req_sel;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            age <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i] || ack[i])     age[i] <= '0;
                else if (age[i] != AGE_MAX) age[i] <= age[i] + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            grant <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n == ISSUE) grant <= winner;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (dl_active)          state_n = DRAIN;
                     else if (|req && !full) state_n = ISSUE;
            ISSUE:   if (sdram_ack)          state_n = IDLE;
            DRAIN:   if (!dl_active && !dl_req) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sdram_req  = 1'b0;
        sdram_we   = 1'b0;
        sdram_addr = '0;
        ack        = '0;
        push       = 1'b0;
        case (state)
            ISSUE: begin
                sdram_req  = 1'b1;
                sdram_addr = addr[int'(grant)*ADDR_W +: ADDR_W];
                if (sdram_ack) begin
                    ack[grant] = 1'b1;
                    push       = 1'b1;
                end
            end
            // Writes wait until every queued read has returned its data.
            DRAIN: if (empty) begin
                sdram_req  = dl_req;
                sdram_we   = 1'b1;
                sdram_addr = dl_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        valid = '0;
        pop   = sdram_valid && !empty;
        if (pop) valid[head] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    overflow_err <= 1'b0;
        else if (sdram_valid && empty) overflow_err <= 1'b1;
    end

    assign sdram_data = dl_data;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed scenarios followed by random traffic, each cycle compared against
// a transaction-level model (owner / drain flag / tag queue / ages).
module tb_sdram_arbiter;
    localparam int NUM_REQ = 4, AGE_LIMIT = 8, PEND_DEPTH = 2, AW = 23;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [NUM_REQ-1:0]     req, ack, valid;
    logic [NUM_REQ*AW-1:0]  addr;
    logic                   dl_active, dl_req;
    logic [AW-1:0]          dl_addr;
    logic [31:0]            dl_data;
    logic                   sdram_req, sdram_we;
    logic [AW-1:0]          sdram_addr;
    logic [31:0]            sdram_data;
    logic                   sdram_ack, sdram_valid, overflow_err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int  m_owner;
    bit  m_drain;
    int  m_q[$];
    int  m_age[NUM_REQ];
    bit  m_ovf;
    logic               e_req, e_we;
    logic [AW-1:0]      e_addr;
    logic [NUM_REQ-1:0] e_ack, e_valid;
    bit                 e_wdef;

    sdram_arbiter #(.NUM_REQ(NUM_REQ), .AGE_LIMIT(AGE_LIMIT), .PEND_DEPTH(PEND_DEPTH)) dut (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .ack(ack), .valid(valid),
        .dl_active(dl_active), .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data),
        .sdram_req(sdram_req), .sdram_we(sdram_we), .sdram_addr(sdram_addr),
        .sdram_data(sdram_data), .sdram_ack(sdram_ack), .sdram_valid(sdram_valid),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_owner = -1;
        m_drain = 1'b0;
        m_q.delete();
        for (int i = 0; i < NUM_REQ; i++) m_age[i] = 0;
        m_ovf = 1'b0;
    endtask

    function automatic int pick();
        for (int i = 0; i < NUM_REQ; i++) if (req[i] && m_age[i] >= AGE_LIMIT) return i;
        for (int i = 0; i < NUM_REQ; i++) if (req[i]) return i;
        return -1;
    endfunction

    task automatic compute_expected();
        e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_ack = '0; e_valid = '0;
        e_wdef = !reset;
        if (reset) begin
            if (m_owner >= 0) begin
                e_req  = 1'b1;
                e_addr = addr[m_owner*AW +: AW];
                e_wdef = 1'b1;
                if (sdram_ack) e_ack[m_owner] = 1'b1;
            end else if (m_drain && m_q.size() == 0) begin
                e_req  = dl_req;
                e_we   = 1'b1;
                e_addr = dl_addr;
                e_wdef = 1'b1;
            end
            if (sdram_valid && m_q.size() > 0) e_valid[m_q[0]] = 1'b1;
        end
    endtask

    task automatic check_model();
        if (!reset) model_clear();
        compute_expected();
        chk("sdram_req",  64'(sdram_req),    64'(e_req));
        chk("ack",        64'(ack),          64'(e_ack));
        chk("valid",      64'(valid),        64'(e_valid));
        chk("sdram_data", 64'(sdram_data),   64'(dl_data));
        chk("overflow",   64'(overflow_err), 64'(m_ovf));
        if (e_wdef) begin
            chk("sdram_we",   64'(sdram_we),   64'(e_we));
            chk("sdram_addr", 64'(sdram_addr), 64'(e_addr));
        end
    endtask

    task automatic update_model();
        int qn;
        int win;
        if (!reset) return;
        qn  = m_q.size();
        win = pick();
        for (int i = 0; i < NUM_REQ; i++)
            m_age[i] = (!req[i] || e_ack[i]) ? 0 : ((m_age[i] < 15) ? m_age[i] + 1 : 15);
        if (sdram_valid) begin
            if (qn > 0) void'(m_q.pop_front());
            else        m_ovf = 1'b1;
        end
        if (m_owner >= 0) begin
            if (sdram_ack) begin
                m_q.push_back(m_owner);
                m_owner = -1;
            end
        end else if (m_drain) begin
            if (!dl_active && !dl_req) m_drain = 1'b0;
        end else if (dl_active) begin
            m_drain = 1'b1;
        end else if (win >= 0 && qn < PEND_DEPTH) begin
            m_owner = win;
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic advance();
        check_model();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic idle_inputs();
        req = '0; sdram_ack = 1'b0; sdram_valid = 1'b0; dl_active = 1'b0; dl_req = 1'b0;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] v);
        addr[i*AW +: AW] = v;
    endtask

    task automatic drain_q();
        sdram_ack = 1'b0;
        for (int c = 0; c < 8 && m_q.size() > 0; c++) begin
            sdram_valid = 1'b1;
            tick();
        end
        sdram_valid = 1'b0;
    endtask

    initial begin
        int  n0;
        bit  got3;
        model_clear();
        e_ack = '0;
        req = 4'b1111; addr = '0; sdram_ack = 1'b1; sdram_valid = 1'b1;
        dl_active = 1'b1; dl_req = 1'b1; dl_addr = 23'h55AA; dl_data = 32'hCAFE_F00D;
        for (int i = 0; i < NUM_REQ; i++) set_addr(i, AW'(32'h100 * (i + 1)));

        // Reset state: everything quiet except the download data pass-through
        @(negedge clk);
        settle();
        chk("rst_sdram_req", 64'(sdram_req), 64'(0));
        chk("rst_ack",       64'(ack), 64'(0));
        chk("rst_valid",     64'(valid), 64'(0));
        chk("rst_ovf",       64'(overflow_err), 64'(0));
        chk("rst_data",      64'(sdram_data), 64'(32'hCAFE_F00D));
        advance();
        idle_inputs();
        tick();
        reset = 1'b1;
        tick();

        // Stray valid at idle sets a sticky overflow
        sdram_valid = 1'b1;
        settle();
        chk("stray_valid_none", 64'(valid), 64'(0));
        advance();
        sdram_valid = 1'b0;
        settle();
        chk("ovf_set", 64'(overflow_err), 64'(1));
        advance();
        repeat (3) tick();
        settle();
        chk("ovf_sticky", 64'(overflow_err), 64'(1));
        advance();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        settle();
        chk("ovf_cleared", 64'(overflow_err), 64'(0));
        advance();

        // Fixed priority: 0110 acks 1 then 2, valids return in that order
        req = 4'b0110;
        tick();
        sdram_ack = 1'b1;
        settle();
        chk("prio_ack1",  64'(ack), 64'(4'b0010));
        chk("prio_addr1", 64'(sdram_addr), 64'(23'h200));
        advance();
        req = 4'b0100; sdram_ack = 1'b0;
        tick();
        sdram_ack = 1'b1;
        settle();
        chk("prio_ack2", 64'(ack), 64'(4'b0100));
        advance();
        req = '0; sdram_ack = 1'b0; sdram_valid = 1'b1;
        settle();
        chk("order_valid1", 64'(valid), 64'(4'b0010));
        advance();
        settle();
        chk("order_valid2", 64'(valid), 64'(4'b0100));
        advance();
        sdram_valid = 1'b0;
        tick();

        // Aging: requester 3 overtakes a continuously requesting requester 0
        req = 4'b1001; sdram_ack = 1'b1;
        n0 = 0; got3 = 1'b0;
        for (int c = 0; c < 40 && !got3; c++) begin
            sdram_valid = (m_q.size() > 0);
            settle();
            if (ack[3])      got3 = 1'b1;
            else if (ack[0]) n0++;
            advance();
        end
        chk("age_promote_seen", 64'(got3), 64'(1));
        chk("age_promote_acks0", 64'(n0), 64'(4));
        req = '0;
        drain_q();

        // Full pending FIFO blocks new grants until a valid frees a slot
        req = 4'b0011; sdram_ack = 1'b1;
        tick();
        tick();
        req = 4'b0010;
        tick();
        tick();
        req = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("full_blocks", 64'(sdram_req), 64'(0));
            advance();
        end
        sdram_valid = 1'b1;
        settle();
        chk("full_valid0", 64'(valid), 64'(4'b0001));
        advance();
        sdram_valid = 1'b0;
        tick();
        settle();
        chk("full_reissue", 64'(sdram_req), 64'(1));
        chk("full_addr2",   64'(sdram_addr), 64'(23'h300));
        advance();
        req = '0;
        drain_q();

        // Download waits for the outstanding read to return
        req = 4'b0010; sdram_ack = 1'b1;
        tick();
        tick();
        req = '0; sdram_ack = 1'b0;
        dl_active = 1'b1; dl_req = 1'b1; dl_addr = 23'h000010; dl_data = 32'h1234_5678;
        tick();
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("dl_held", 64'(sdram_req), 64'(0));
            advance();
        end
        sdram_valid = 1'b1;
        settle();
        chk("dl_read_valid", 64'(valid), 64'(4'b0010));
        chk("dl_still_held", 64'(sdram_req), 64'(0));
        advance();
        sdram_valid = 1'b0;
        settle();
        chk("dl_write_req",  64'(sdram_req), 64'(1));
        chk("dl_write_we",   64'(sdram_we), 64'(1));
        chk("dl_write_addr", 64'(sdram_addr), 64'(23'h000010));
        advance();
        dl_req = 1'b0; dl_active = 1'b0;
        tick();
        tick();

        // Reset in ISSUE, then clean restart
        req = 4'b1000; set_addr(3, 23'h71234);
        tick();
        reset = 1'b0;
        settle();
        chk("rst_issue_req", 64'(sdram_req), 64'(0));
        advance();
        reset = 1'b1;
        tick();
        sdram_ack = 1'b1;
        settle();
        chk("restart_req",  64'(sdram_req), 64'(1));
        chk("restart_addr", 64'(sdram_addr), 64'(23'h71234));
        chk("restart_ack",  64'(ack), 64'(4'b1000));
        advance();
        req = '0; sdram_ack = 1'b0; sdram_valid = 1'b1;
        settle();
        chk("restart_valid", 64'(valid), 64'(4'b1000));
        advance();
        sdram_valid = 1'b0;

        // Reset discards an outstanding read; its late valid is a stray
        req = 4'b0010; sdram_ack = 1'b1;
        tick();
        tick();
        req = '0; sdram_ack = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        sdram_valid = 1'b1;
        settle();
        chk("discard_valid", 64'(valid), 64'(0));
        advance();
        sdram_valid = 1'b0;
        settle();
        chk("discard_ovf", 64'(overflow_err), 64'(1));
        advance();
        reset = 1'b0;
        tick();
        reset = 1'b1;

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i]) begin
                    if (e_ack[i]) begin
                        if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                        else set_addr(i, AW'($urandom));
                    end else if ($urandom_range(0, 63) == 0) begin
                        req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    set_addr(i, AW'($urandom));
                end
            end
            if ($urandom_range(0, 39) == 0) dl_active = ~dl_active;
            dl_req      = dl_active && ($urandom_range(0, 1) == 1);
            dl_addr     = AW'($urandom);
            dl_data     = $urandom;
            sdram_ack   = ($urandom_range(0, 1) == 1);
            sdram_valid = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0)
                                           : ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
